// File: rtl/toggle_event_decoder_if.sv
// rtl/toggle_event_decoder_if.sv - pending-event valid/ready handshake bundle
interface toggle_event_decoder_if #(
    parameter int CNT_W = 4
) ();
    logic             evt_valid;
    logic             evt_ready;
    logic [CNT_W-1:0] evt_count;

    modport master (output evt_valid, output evt_count, input evt_ready);
    modport slave  (input evt_valid, input evt_count, output evt_ready);
endinterface

// File: rtl/toggle_event_decoder.sv
// rtl/toggle_event_decoder.sv - recovers events from a toggle-encoded level
// Synchronises the toggle, detects each level change, counts pending events.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog_in,
    input  logic clr_ovf,
    output logic tog_level,
    output logic evt_pulse,
    output logic overflow,
    toggle_event_decoder_if.master evt
);
    localparam int              WW      = $clog2(SYNC_STAGES + 2) + 1;
    localparam logic [WW-1:0]   ARM_AT  = WW'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {ST_WARMUP, ST_ARMED} state_t;

    state_t                 state_q, state_d;
    logic [WW-1:0]          warm_q, warm_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   armed;
    logic                   evt_det;
    logic                   accept;

    assign tog_level     = sync_q[SYNC_STAGES-1];
    assign evt_pulse     = pulse_q;
    assign overflow      = ovf_q;
    assign evt.evt_count = cnt_q;
    assign evt.evt_valid = (cnt_q != '0);

    assign armed   = (state_q == ST_ARMED);
    assign evt_det = armed & (tog_level ^ prev_q);
    assign accept  = evt.evt_valid & evt.evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WARMUP;
            warm_q  <= '0;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tog_in};
            prev_q  <= tog_level;
            pulse_q <= evt_det;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Stay unarmed until the baseline register holds the first post-reset sample.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (state_q == ST_WARMUP) begin
            warm_d = warm_q + 1'b1;
            if (warm_q == ARM_AT) begin
                state_d = ST_ARMED;
            end
        end
    end

    // A simultaneous event and accept cancel out, even at saturation.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (evt_det && !accept) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (accept && !evt_det) begin
            cnt_d = cnt_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb/tb_toggle_event_decoder.sv - bench for toggle_event_decoder
module tb_toggle_event_decoder;
    localparam int S    = 2;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk;
    logic rst_n;
    logic tog_in;
    logic clr_ovf;
    logic tog_level;
    logic evt_pulse;
    logic overflow;

    toggle_event_decoder_if #(.CNT_W(CW)) bus ();

    toggle_event_decoder #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tog_in    (tog_in),
        .clr_ovf   (clr_ovf),
        .tog_level (tog_level),
        .evt_pulse (evt_pulse),
        .overflow  (overflow),
        .evt       (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors    = 0;
    int miscompares = 0;

    // Reference: per-edge history of sampled tog_in since the last reset release.
    int hist[$];
    int m_cnt;
    bit m_ovf;
    bit m_pulse;
    bit m_lvl;
    logic t_cur;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("evt_pulse", {7'd0, evt_pulse}, {7'd0, m_pulse});
        chk("evt_count", {4'd0, bus.evt_count}, 8'(m_cnt));
        chk("evt_valid", {7'd0, bus.evt_valid}, {7'd0, (m_cnt != 0)});
        chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
        chk("tog_level", {7'd0, tog_level}, {7'd0, m_lvl});
    endtask

    task automatic step(input logic t, input logic r, input logic c);
        int n;
        bit ev, acc, sat;
        tog_in        = t;
        bus.evt_ready = r;
        clr_ovf       = c;
        @(posedge clk);
        hist.push_back(int'(t));
        n   = hist.size();
        ev  = (n >= S + 2) && (hist[n-1-S] != hist[n-2-S]);
        acc = (m_cnt != 0) && r;
        sat = ev && !acc && (m_cnt == MAXC);
        if (ev && !acc && !sat) m_cnt++;
        else if (acc && !ev)    m_cnt--;
        if (sat)    m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        m_pulse = ev;
        m_lvl   = (n >= S) ? hist[n-S][0] : 1'b0;
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int cycles, input logic t, input logic r, input logic c);
        for (int i = 0; i < cycles; i++) step(t, r, c);
    endtask

    task automatic flip_run(input int spacing, input logic r);
        t_cur = ~t_cur;
        run(spacing, t_cur, r, 1'b0);
    endtask

    // Reset asserted between edges must clear outputs without a clock edge.
    task automatic do_reset(input logic lvl);
        tog_in = lvl;
        t_cur  = lvl;
        #2;
        rst_n = 1'b0;
        #1;
        hist.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_pulse = 1'b0;
        m_lvl   = 1'b0;
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b1;
        tog_in        = 1'b1;
        clr_ovf       = 1'b0;
        bus.evt_ready = 1'b0;
        t_cur         = 1'b1;
        m_cnt = 0; m_ovf = 0; m_pulse = 0; m_lvl = 0;
        @(negedge clk);

        // high level at release must not produce an event
        do_reset(1'b1);
        run(10, 1'b1, 1'b0, 1'b0);

        // single event then one accept
        flip_run(5, 1'b0);
        chk("single_count", {4'd0, bus.evt_count}, 8'd1);
        run(1, t_cur, 1'b1, 1'b0);
        run(2, t_cur, 1'b0, 1'b0);

        // five events then drain
        for (int i = 0; i < 5; i++) flip_run(3, 1'b0);
        run(3, t_cur, 1'b0, 1'b0);
        chk("five_count", {4'd0, bus.evt_count}, 8'd5);
        run(6, t_cur, 1'b1, 1'b0);

        // saturation and overflow clear
        for (int i = 0; i < 16; i++) flip_run(3, 1'b0);
        run(3, t_cur, 1'b0, 1'b0);
        chk("sat_count", {4'd0, bus.evt_count}, 8'd15);
        chk("sat_ovf", {7'd0, overflow}, 8'd1);
        run(1, t_cur, 1'b0, 1'b1);
        chk("clr_ovf", {7'd0, overflow}, 8'd0);

        // clr_ovf on the same edge as a saturating event: set wins
        t_cur = ~t_cur;
        run(2, t_cur, 1'b0, 1'b0);
        run(1, t_cur, 1'b0, 1'b1);
        chk("set_wins", {7'd0, overflow}, 8'd1);
        run(2, t_cur, 1'b0, 1'b0);

        // event and accept on the same edge at count 3
        run(12, t_cur, 1'b1, 1'b0);
        chk("drain_to3", {4'd0, bus.evt_count}, 8'd3);
        t_cur = ~t_cur;
        run(2, t_cur, 1'b0, 1'b0);
        run(1, t_cur, 1'b1, 1'b0);
        chk("evt_and_acc", {4'd0, bus.evt_count}, 8'd3);
        run(3, t_cur, 1'b0, 1'b0);

        // mid-operation reset at count 7, re-arm with high level
        for (int i = 0; i < 4; i++) flip_run(3, 1'b0);
        run(3, t_cur, 1'b0, 1'b0);
        chk("pre_rst_count", {4'd0, bus.evt_count}, 8'd7);
        do_reset(1'b1);
        run(8, 1'b1, 1'b0, 1'b0);
        t_cur = 1'b0;
        run(6, 1'b0, 1'b0, 1'b0);
        chk("post_rst_one", {4'd0, bus.evt_count}, 8'd1);

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            int hold;
            if ($urandom_range(0, 39) == 0) do_reset(1'($urandom_range(0, 1)));
            hold = $urandom_range(2, 5);
            if ($urandom_range(0, 2) != 0) t_cur = ~t_cur;
            for (int j = 0; j < hold; j++)
                step(t_cur, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
